ifetch_ctrl: RTL and testbench

Instruction-fetch controller for the pipelined CPU. It owns the address port of the combinational instruction memory: it holds the fetch PC, drives `imem_addr`, and captures `imem_rd` into a small prefetch queue. Decode consumes the queue through a valid/ready handshake. A branch/jump redirect from execute flushes the queue and restarts fetch at the new PC.

---
 rtl/ifetch_ctrl.sv | 179 +++++++++++++++++
 tb/tb_ifetch_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_ctrl.sv
// ifetch_ctrl: instruction-fetch controller with a prefetch queue.
// Holds the fetch PC and drives imem_addr. The combinational imem
// read data is captured into a circular prefetch queue that decode
// drains through a valid/ready handshake. A redirect flushes the
// queue and restarts fetch at redirect_pc.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   fetch_en              allow new fetches (queue still drains when low)
//   redirect_valid/_pc    flush and restart fetch at redirect_pc
//   imem_addr / imem_rd   instruction memory address / read data
//   out_valid/ready       head handshake toward decode
//   out_instr / out_pc    registered head instruction and its word address
//   perf_fetch_cnt        queue writes (saturating)
//   perf_stall_cnt        cycles spent in STALL (saturating)
//
// Optional feature: define IFETCH_PERF_EN to build the perf counters;
// otherwise both perf outputs are tied to zero.
module ifetch_ctrl #(
    parameter int unsigned AW    = 6,
    parameter int unsigned DW    = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          fetch_en,
    input  logic          redirect_valid,
    input  logic [AW-1:0] redirect_pc,
    output logic [AW-1:0] imem_addr,
    input  logic [DW-1:0] imem_rd,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_instr,
    output logic [AW-1:0] out_pc,
    output logic [15:0]   perf_fetch_cnt,
    output logic [15:0]   perf_stall_cnt
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned EW = AW + DW;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        STALL = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [AW-1:0]  pc_q, pc_d;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           valid_q, valid_d;
    logic [EW-1:0]  head_q, head_d;
    logic [EW-1:0]  mem [DEPTH];
    logic           push, pop, full, empty_after_pop;

    // Next-state, queue bookkeeping and registered-head selection
    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        wr_ptr_d        = wr_ptr_q;
        rd_ptr_d        = rd_ptr_q;
        count_d         = count_q;
        head_d          = head_q;
        push            = 1'b0;
        pop             = 1'b0;
        full            = (count_q == CW'(DEPTH));
        empty_after_pop = 1'b0;

        if (redirect_valid) begin
            pc_d     = redirect_pc;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            state_d  = fetch_en ? FETCH : IDLE;
        end else begin
            pop  = valid_q && out_ready;
            // A full queue still accepts a write when the head leaves this cycle
            push = (state_q == FETCH) && fetch_en && (!full || pop);

            if (push) begin
                pc_d     = pc_q + AW'(1);
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CW'(1);
            end

            unique case (state_q)
                IDLE: begin
                    if (fetch_en) state_d = FETCH;
                end
                FETCH: begin
                    if (!fetch_en)                              state_d = IDLE;
                    else if ((count_d == CW'(DEPTH)) && !pop)   state_d = STALL;
                end
                STALL: begin
                    if (!fetch_en) state_d = IDLE;
                    else if (pop)  state_d = FETCH;
                end
                default: state_d = IDLE;
            endcase
        end

        valid_d = (count_d != CW'(0));

        // New head comes straight from the write when the queue would otherwise be empty
        empty_after_pop = (count_q == CW'(0)) || (pop && (count_q == CW'(1)));
        if (valid_d) begin
            head_d = (push && empty_after_pop) ? {pc_q, imem_rd} : mem[rd_ptr_d];
        end
    end

    // Control and head registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            pc_q     <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            head_q   <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            head_q   <= head_d;
        end
    end

    // Queue storage; contents are don't-care whenever count says so
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= {pc_q, imem_rd};
        end
    end

    assign imem_addr = pc_q;
    assign out_valid = valid_q;
    assign out_pc    = head_q[EW-1:DW];
    assign out_instr = head_q[DW-1:0];

`ifdef IFETCH_PERF_EN
    logic [15:0] fetch_cnt_q, stall_cnt_q;

    // Saturating performance counters
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (push && (fetch_cnt_q != 16'hFFFF)) begin
                fetch_cnt_q <= fetch_cnt_q + 16'd1;
            end
            if ((state_q == STALL) && (stall_cnt_q != 16'hFFFF)) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
        end
    end

    assign perf_fetch_cnt = fetch_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;
`else
    assign perf_fetch_cnt = 16'd0;
    assign perf_stall_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Self-checking bench for ifetch_ctrl: directed steps in one initial
// block, a scoreboard queue of expected head pcs checked at every pop.
module tb_ifetch_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        fetch_en;
    logic        redirect_valid;
    logic [5:0]  redirect_pc;
    logic [5:0]  imem_addr;
    logic [31:0] imem_rd;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [5:0]  out_pc;
    logic [15:0] perf_fetch_cnt;
    logic [15:0] perf_stall_cnt;

    int total = 0;
    int bad   = 0;
    bit mon_en = 1'b1;
    logic [5:0] exp_q[$];

    ifetch_ctrl #(.AW(6), .DW(32), .DEPTH(4)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_addr      (imem_addr),
        .imem_rd        (imem_rd),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
    );

    always #5 clk = ~clk;

    // Instruction memory: word i holds 0x1000_0000 + i
    assign imem_rd = 32'h1000_0000 + 32'(imem_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [5:0] first, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(6'(first + 6'(i)));
    endtask

    // Scoreboard: every accepted head must match the next expected pc
    always @(negedge clk) begin
        if (mon_en && reset_n && out_valid && out_ready && !redirect_valid) begin
            logic [5:0] e;
            total++;
            assert (exp_q.size() != 0) else begin
                bad++;
                $error("FAIL sb_unexpected_pop observed_pc=%h expected=none", out_pc);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("sb_pc", 32'(out_pc), 32'(e));
                chk("sb_instr", out_instr, 32'h1000_0000 + 32'(e));
            end
        end
    end

    initial begin
        reset_n        = 1'b0;
        fetch_en       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b0;
        tick();
        chk("rst_addr",   32'(imem_addr), 32'd0);
        chk("rst_valid",  32'(out_valid), 32'd0);
        chk("rst_instr",  out_instr,      32'd0);
        chk("rst_pc",     32'(out_pc),    32'd0);
        chk("rst_pfetch", 32'(perf_fetch_cnt), 32'd0);
        chk("rst_pstall", 32'(perf_stall_cnt), 32'd0);

        // Streaming fetch with decode always ready
        reset_n   = 1'b1;
        fetch_en  = 1'b1;
        out_ready = 1'b1;
        push_exp(6'd0, 7);
        tick();
        chk("lat_valid0", 32'(out_valid), 32'd0);
        chk("lat_addr0",  32'(imem_addr), 32'd0);
        tick();
        chk("lat_valid1", 32'(out_valid), 32'd1);
        chk("lat_pc0",    32'(out_pc),    32'd0);
        chk("lat_addr1",  32'(imem_addr), 32'd1);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("stream_valid", 32'(out_valid), 32'd1);
            chk("stream_pc",    32'(out_pc),    32'(i + 1));
        end
        fetch_en = 1'b0;
        chk("stream_addr", 32'(imem_addr), 32'd7);
        tick();
        chk("stream_drained", 32'(out_valid), 32'd0);
        tick();
        tick();
        chk("idle_pc_hold", 32'(imem_addr), 32'd7);

        // Backpressure: fill to STALL
        redirect_valid = 1'b1;
        redirect_pc    = 6'd0;
        fetch_en       = 1'b1;
        out_ready      = 1'b0;
        tick();
        redirect_valid = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        chk("stall_addr",  32'(imem_addr), 32'd4);
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_head",  32'(out_pc),    32'd0);
`ifdef IFETCH_PERF_EN
        chk("stall_pstall", 32'(perf_stall_cnt), 32'd6);
        chk("stall_pfetch", 32'(perf_fetch_cnt), 32'd11);
`else
        chk("stall_pstall", 32'(perf_stall_cnt), 32'd0);
        chk("stall_pfetch", 32'(perf_fetch_cnt), 32'd0);
`endif

        // Drain three, then redirect while three entries are queued
        push_exp(6'd0, 3);
        out_ready = 1'b1;
        tick();
        tick();
        tick();
        chk("pre_redir_head", 32'(out_pc),    32'd3);
        chk("pre_redir_addr", 32'(imem_addr), 32'd6);
        redirect_valid = 1'b1;
        redirect_pc    = 6'h2A;
        tick();
        redirect_valid = 1'b0;
        chk("redir_addr",  32'(imem_addr), 32'h2A);
        chk("redir_flush", 32'(out_valid), 32'd0);
        push_exp(6'h2A, 2);
        tick();
        chk("redir_valid", 32'(out_valid), 32'd1);
        chk("redir_head",  32'(out_pc),    32'h2A);
        tick();
        fetch_en = 1'b0;
        tick();
        chk("redir_drained", 32'(out_valid), 32'd0);
        chk("redir_addr_end", 32'(imem_addr), 32'h2C);

        // PC wrap across 2^AW
        redirect_valid = 1'b1;
        redirect_pc    = 6'h3E;
        fetch_en       = 1'b1;
        push_exp(6'h3E, 4);
        tick();
        redirect_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        fetch_en = 1'b0;
        chk("wrap_addr", 32'(imem_addr), 32'd2);
        tick();
        chk("wrap_drained", 32'(out_valid), 32'd0);

        // fetch_en drop: PC freezes, queue holds, then drains
        redirect_valid = 1'b1;
        redirect_pc    = 6'h10;
        fetch_en       = 1'b1;
        out_ready      = 1'b0;
        tick();
        redirect_valid = 1'b0;
        tick();
        tick();
        fetch_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("freeze_addr",  32'(imem_addr), 32'h12);
            chk("freeze_valid", 32'(out_valid), 32'd1);
            chk("freeze_head",  32'(out_pc),    32'h10);
        end
        push_exp(6'h10, 2);
        out_ready = 1'b1;
        tick();
        tick();
        chk("freeze_drained", 32'(out_valid), 32'd0);

        // Asynchronous reset mid-cycle with entries queued
        out_ready = 1'b0;
        fetch_en  = 1'b1;
        tick();
        tick();
        tick();
        chk("prerst_valid", 32'(out_valid), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_addr",  32'(imem_addr), 32'd0);
        chk("arst_pc",    32'(out_pc),    32'd0);
        chk("arst_instr", out_instr,      32'd0);
        chk("arst_pfetch", 32'(perf_fetch_cnt), 32'd0);
        fetch_en = 1'b0;
        tick();
        reset_n = 1'b1;

        // Perf counter saturation (or tie-off when not built)
        mon_en    = 1'b0;
        fetch_en  = 1'b1;
        out_ready = 1'b1;
`ifdef IFETCH_PERF_EN
        for (int i = 0; i < 65600; i++) tick();
        chk("perf_fetch_sat", 32'(perf_fetch_cnt), 32'h0000_FFFF);
        chk("perf_stall_none", 32'(perf_stall_cnt), 32'd0);
`else
        for (int i = 0; i < 50; i++) tick();
        chk("perf_fetch_off", 32'(perf_fetch_cnt), 32'd0);
        chk("perf_stall_off", 32'(perf_stall_cnt), 32'd0);
`endif
        fetch_en = 1'b0;
        tick();
        tick();
        chk("sb_leftover", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
